// File: rtl/addr_dec_pkg.sv
// Shared types for the N-unit address decoder: FSM state codes and response kinds.
package addr_dec_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_DEC_ERR = 2'd1,
        RSP_TMO     = 2'd2
    } resp_e;

    function automatic logic resp_is_err(input resp_e rsp);
        return (rsp != RSP_OK);
    endfunction

endpackage

// File: rtl/unit_sel_decoder.sv
// Combinational unit index decoder: one-hot select plus in-range flag.
module unit_sel_decoder #(
    parameter int NUM_UNITS = 5,
    parameter int IDX_W     = 3
) (
    input  logic [IDX_W-1:0]     idx,
    output logic [NUM_UNITS-1:0] onehot,
    output logic                 in_range
);

    // One bit per unit; out-of-range indices produce an all-zero vector
    always_comb begin
        onehot   = '0;
        in_range = (int'(idx) < NUM_UNITS);
        for (int i = 0; i < NUM_UNITS; i++) begin
            onehot[i] = (int'(idx) == i);
        end
    end

endmodule

// File: rtl/unit_addr_decoder_n.sv
// Single-master to NUM_UNITS-slave request router with decode-error and
// ack-timeout responses; all outputs registered.
module unit_addr_decoder_n
    import addr_dec_pkg::*;
#(
    parameter int NUM_UNITS   = 5,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 wr_rd_s_in,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [DATA_W-1:0]    wr_data_in,
    output logic [DATA_W-1:0]    rd_data_out,
    output logic                 ack_out,
    output logic                 err_out,
    output logic [NUM_UNITS-1:0] sel_en_out,
    output logic                 wr_rd_s_out,
    output logic [ADDR_W-1:0]    addr_out,
    output logic [DATA_W-1:0]    wr_data_out,
    input  logic [DATA_W-1:0]    rd_data_in,
    input  logic [NUM_UNITS-1:0] ack_in
);

    localparam int IDX_W = $clog2(NUM_UNITS);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]           state_r,   state_s;
    logic [CNT_W-1:0]     cnt_r,     cnt_s;
    logic [NUM_UNITS-1:0] sel_en_r,  sel_en_s;
    logic                 wr_rd_r,   wr_rd_s;
    logic [ADDR_W-1:0]    addr_r,    addr_s;
    logic [DATA_W-1:0]    wr_data_r, wr_data_s;
    logic [DATA_W-1:0]    rd_data_r, rd_data_s;
    logic                 ack_r,     ack_s;
    logic                 err_r,     err_s;
    logic                 ready_r,   ready_s;
    resp_e                resp_s;

    logic [NUM_UNITS-1:0] dec_onehot_s;
    logic                 dec_in_range_s;
    logic                 ack_hit_s;

    unit_sel_decoder #(
        .NUM_UNITS (NUM_UNITS),
        .IDX_W     (IDX_W)
    ) u_sel_dec (
        .idx      (addr_in[ADDR_W-1 -: IDX_W]),
        .onehot   (dec_onehot_s),
        .in_range (dec_in_range_s)
    );

    // Only the selected unit's acknowledge counts; sel_en_r is the latched one-hot
    assign ack_hit_s = |(ack_in & sel_en_r);

    // Next-state and next-output computation for the request FSM
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sel_en_s  = sel_en_r;
        wr_rd_s   = wr_rd_r;
        addr_s    = addr_r;
        wr_data_s = wr_data_r;
        rd_data_s = rd_data_r;
        ack_s     = 1'b0;
        resp_s    = RSP_OK;
        case (state_r)
            ST_IDLE: begin
                if (valid_in) begin
                    wr_rd_s   = wr_rd_s_in;
                    addr_s    = addr_in;
                    wr_data_s = wr_data_in;
                    cnt_s     = '0;
                    if (dec_in_range_s) begin
                        state_s  = ST_ACCESS;
                        sel_en_s = dec_onehot_s;
                    end else begin
                        state_s   = ST_RESP;
                        sel_en_s  = '0;
                        ack_s     = 1'b1;
                        resp_s    = RSP_DEC_ERR;
                        rd_data_s = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // An ack on the final counted cycle still completes without error
                if (ack_hit_s) begin
                    state_s   = ST_RESP;
                    sel_en_s  = '0;
                    ack_s     = 1'b1;
                    rd_data_s = wr_rd_r ? '0 : rd_data_in;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = ST_RESP;
                    sel_en_s  = '0;
                    ack_s     = 1'b1;
                    resp_s    = RSP_TMO;
                    rd_data_s = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s  = ST_IDLE;
                sel_en_s = '0;
            end
        endcase
        err_s   = ack_s & resp_is_err(resp_s);
        ready_s = (state_s == ST_IDLE);
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            sel_en_r  <= '0;
            wr_rd_r   <= 1'b0;
            addr_r    <= '0;
            wr_data_r <= '0;
            rd_data_r <= '0;
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            sel_en_r  <= sel_en_s;
            wr_rd_r   <= wr_rd_s;
            addr_r    <= addr_s;
            wr_data_r <= wr_data_s;
            rd_data_r <= rd_data_s;
            ack_r     <= ack_s;
            err_r     <= err_s;
            ready_r   <= ready_s;
        end
    end

    assign ready_out   = ready_r;
    assign sel_en_out  = sel_en_r;
    assign wr_rd_s_out = wr_rd_r;
    assign addr_out    = addr_r;
    assign wr_data_out = wr_data_r;
    assign rd_data_out = rd_data_r;
    assign ack_out     = ack_r;
    assign err_out     = err_r;

endmodule

// File: tb/tb_unit_addr_decoder_n.sv
// Directed bench for unit_addr_decoder_n: per-cycle vector table plus sequences
// for timeout, ignored acks/requests and mid-transaction reset.
module tb_unit_addr_decoder_n;

    logic       clock;
    logic       reset;
    logic       valid_in;
    logic       ready_out;
    logic       wr_rd_s_in;
    logic [7:0] addr_in;
    logic [7:0] wr_data_in;
    logic [7:0] rd_data_out;
    logic       ack_out;
    logic       err_out;
    logic [4:0] sel_en_out;
    logic       wr_rd_s_out;
    logic [7:0] addr_out;
    logic [7:0] wr_data_out;
    logic [7:0] rd_data_in;
    logic [4:0] ack_in;

    int checks = 0;
    int errors = 0;

    unit_addr_decoder_n #(
        .NUM_UNITS   (5),
        .ADDR_W      (8),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .wr_rd_s_in  (wr_rd_s_in),
        .addr_in     (addr_in),
        .wr_data_in  (wr_data_in),
        .rd_data_out (rd_data_out),
        .ack_out     (ack_out),
        .err_out     (err_out),
        .sel_en_out  (sel_en_out),
        .wr_rd_s_out (wr_rd_s_out),
        .addr_out    (addr_out),
        .wr_data_out (wr_data_out),
        .rd_data_in  (rd_data_in),
        .ack_in      (ack_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One row per cycle: outputs expected in this cycle, then inputs driven in it
    typedef struct {
        logic       valid;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [4:0] ack;
        logic [7:0] rdin;
        logic       e_ready;
        logic [4:0] e_sel;
        logic       e_ack;
        logic       e_err;
        logic [7:0] e_rd;
        logic [7:0] e_addr;
        logic [7:0] e_wdata;
        logic       e_wr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic wr, input logic [7:0] a,
                         input logic [7:0] wd, input logic [4:0] ak, input logic [7:0] rd);
        valid_in   = v;
        wr_rd_s_in = wr;
        addr_in    = a;
        wr_data_in = wd;
        ack_in     = ak;
        rd_data_in = rd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sel"},   32'(sel_en_out),  32'h0);
        chk({tag, ".ack"},   32'(ack_out),     32'h0);
        chk({tag, ".err"},   32'(err_out),     32'h0);
        chk({tag, ".rd"},    32'(rd_data_out), 32'h0);
        chk({tag, ".addr"},  32'(addr_out),    32'h0);
        chk({tag, ".wdata"}, 32'(wr_data_out), 32'h0);
        chk({tag, ".wr"},    32'(wr_rd_s_out), 32'h0);
        chk({tag, ".ready"}, 32'(ready_out),   32'h1);
    endtask

    initial begin
        //           v    wr   addr   wdata  ack       rdin   rdy  sel       ack  err  rd     addr   wdata  wr
        vecs[0]  = '{1'b1,1'b1,8'h45,8'h3C,5'b00000,8'h00, 1'b1,5'b00000,1'b0,1'b0,8'h00,8'h00,8'h00,1'b0};
        vecs[1]  = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b0,5'b00100,1'b0,1'b0,8'h00,8'h45,8'h3C,1'b1};
        vecs[2]  = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b0,5'b00100,1'b0,1'b0,8'h00,8'h45,8'h3C,1'b1};
        vecs[3]  = '{1'b0,1'b0,8'h00,8'h00,5'b00100,8'h00, 1'b0,5'b00100,1'b0,1'b0,8'h00,8'h45,8'h3C,1'b1};
        vecs[4]  = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b0,5'b00000,1'b1,1'b0,8'h00,8'h45,8'h3C,1'b1};
        vecs[5]  = '{1'b1,1'b0,8'h8F,8'h00,5'b00000,8'h00, 1'b1,5'b00000,1'b0,1'b0,8'h00,8'h45,8'h3C,1'b1};
        vecs[6]  = '{1'b0,1'b0,8'h00,8'h00,5'b10000,8'hA5, 1'b0,5'b10000,1'b0,1'b0,8'h00,8'h8F,8'h00,1'b0};
        vecs[7]  = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b0,5'b00000,1'b1,1'b0,8'hA5,8'h8F,8'h00,1'b0};
        vecs[8]  = '{1'b1,1'b0,8'hE0,8'h00,5'b00000,8'h00, 1'b1,5'b00000,1'b0,1'b0,8'hA5,8'h8F,8'h00,1'b0};
        vecs[9]  = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b0,5'b00000,1'b1,1'b1,8'h00,8'hE0,8'h00,1'b0};
        vecs[10] = '{1'b1,1'b1,8'h00,8'h11,5'b00000,8'h00, 1'b1,5'b00000,1'b0,1'b0,8'h00,8'hE0,8'h00,1'b0};
        vecs[11] = '{1'b0,1'b0,8'h00,8'h00,5'b00001,8'h99, 1'b0,5'b00001,1'b0,1'b0,8'h00,8'h00,8'h11,1'b1};
        vecs[12] = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b0,5'b00000,1'b1,1'b0,8'h00,8'h00,8'h11,1'b1};
        vecs[13] = '{1'b0,1'b0,8'h00,8'h00,5'b00000,8'h00, 1'b1,5'b00000,1'b0,1'b0,8'h00,8'h00,8'h11,1'b1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00);
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            chk($sformatf("vec%0d.ready", i), 32'(ready_out),   32'(vecs[i].e_ready));
            chk($sformatf("vec%0d.sel", i),   32'(sel_en_out),  32'(vecs[i].e_sel));
            chk($sformatf("vec%0d.ack", i),   32'(ack_out),     32'(vecs[i].e_ack));
            chk($sformatf("vec%0d.err", i),   32'(err_out),     32'(vecs[i].e_err));
            chk($sformatf("vec%0d.rd", i),    32'(rd_data_out), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d.addr", i),  32'(addr_out),    32'(vecs[i].e_addr));
            chk($sformatf("vec%0d.wdata", i), 32'(wr_data_out), 32'(vecs[i].e_wdata));
            chk($sformatf("vec%0d.wr", i),    32'(wr_rd_s_out), 32'(vecs[i].e_wr));
            drive(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdin);
            next_cycle();
        end

        // Timeout: no ack for 16 ACCESS cycles, then an error response in cycle 17
        drive(1'b1, 1'b0, 8'h20, 8'h00, 5'b00000, 8'h00);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00);
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("tmo.c%0d.sel", c), 32'(sel_en_out), 32'h02);
            chk($sformatf("tmo.c%0d.ack", c), 32'(ack_out),    32'h0);
            next_cycle();
        end
        chk("tmo.ack", 32'(ack_out),     32'h1);
        chk("tmo.err", 32'(err_out),     32'h1);
        chk("tmo.rd",  32'(rd_data_out), 32'h0);
        chk("tmo.sel", 32'(sel_en_out),  32'h0);
        next_cycle();
        chk("tmo.ready", 32'(ready_out), 32'h1);
        chk("tmo.ackclr", 32'(ack_out),  32'h0);

        // Ack arriving on the last counted cycle beats the timeout
        drive(1'b1, 1'b0, 8'h20, 8'h00, 5'b00000, 8'h00);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00);
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("late.c%0d.sel", c), 32'(sel_en_out), 32'h02);
            if (c == 16) begin
                ack_in     = 5'b00010;
                rd_data_in = 8'h5A;
            end
            next_cycle();
        end
        ack_in     = 5'b00000;
        rd_data_in = 8'h00;
        chk("late.ack", 32'(ack_out),     32'h1);
        chk("late.err", 32'(err_out),     32'h0);
        chk("late.rd",  32'(rd_data_out), 32'h5A);
        next_cycle();

        // Acks from other units and new request strobes are ignored during ACCESS
        drive(1'b1, 1'b0, 8'h3F, 8'h00, 5'b00000, 8'h00);
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("ign.c%0d.sel", c),  32'(sel_en_out), 32'h02);
            chk($sformatf("ign.c%0d.ack", c),  32'(ack_out),    32'h0);
            chk($sformatf("ign.c%0d.addr", c), 32'(addr_out),   32'h3F);
            drive(c[0], 1'b1, 8'hE0, 8'hFF, 5'b00001, 8'h66);
            next_cycle();
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00010, 8'h77);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00);
        chk("ign.ack", 32'(ack_out),     32'h1);
        chk("ign.err", 32'(err_out),     32'h0);
        chk("ign.rd",  32'(rd_data_out), 32'h77);
        chk("ign.wr",  32'(wr_rd_s_out), 32'h0);
        next_cycle();

        // Reset during ACCESS clears everything without waiting for a clock edge
        drive(1'b1, 1'b1, 8'h61, 8'h77, 5'b00000, 8'h00);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00);
        chk("mid.sel", 32'(sel_en_out), 32'h08);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        next_cycle();
        #2 reset = 1'b0;
        next_cycle();
        chk("post.ready", 32'(ready_out), 32'h1);
        drive(1'b1, 1'b0, 8'h9A, 8'h00, 5'b00000, 8'h00);
        next_cycle();
        chk("post.sel", 32'(sel_en_out), 32'h10);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b10000, 8'h3C);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 5'b00000, 8'h00);
        chk("post.ack", 32'(ack_out),     32'h1);
        chk("post.err", 32'(err_out),     32'h0);
        chk("post.rd",  32'(rd_data_out), 32'h3C);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
